// File: rtl/wb_gpio_pkg.sv
// Register map shared by the GPIO/interrupt block and anything that drives it over Wishbone.
// Addresses are byte addresses on the 5-bit wb_adr_i bus.
package wb_gpio_pkg;

    localparam int ADR_W = 5;

    localparam logic [ADR_W-1:0] ADDR_OEN     = 5'h00;
    localparam logic [ADR_W-1:0] ADDR_SET     = 5'h04;
    localparam logic [ADR_W-1:0] ADDR_CLR     = 5'h08;
    localparam logic [ADR_W-1:0] ADDR_OUT     = 5'h0C;
    localparam logic [ADR_W-1:0] ADDR_IN      = 5'h10;
    localparam logic [ADR_W-1:0] ADDR_RISE_EN = 5'h14;
    localparam logic [ADR_W-1:0] ADDR_FALL_EN = 5'h18;
    localparam logic [ADR_W-1:0] ADDR_STATUS  = 5'h1C;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser followed by a one-cycle delay stage for edge detection.
// All flops reset to 0, so a pad that is high out of reset reports exactly one rising edge.
module gpio_sync_edge #(
    parameter int G_WIDTH       = 8,
    parameter int G_SYNC_STAGES = 2
) (
    input  logic               clk_sys_i,
    input  logic               rst_n_i,
    input  logic [G_WIDTH-1:0] gpio_in_i,
    output logic [G_WIDTH-1:0] sync,
    output logic [G_WIDTH-1:0] rise,
    output logic [G_WIDTH-1:0] fall
);

    logic [G_SYNC_STAGES-1:0][G_WIDTH-1:0] sync_q;
    logic [G_WIDTH-1:0]                    dly_q;

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q <= {sync_q[G_SYNC_STAGES-2:0], gpio_in_i};
            dly_q  <= sync_q[G_SYNC_STAGES-1];
        end
    end

    assign sync = sync_q[G_SYNC_STAGES-1];
    assign rise = sync & ~dly_q;
    assign fall = ~sync & dly_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO block with per-line output enable and edge-triggered interrupts.
// One-cycle registered ack; a held strobe therefore sees an ack every second cycle.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int G_WIDTH       = 8,
    parameter int G_SYNC_STAGES = 2
) (
    input  logic               clk_sys_i,
    input  logic               rst_n_i,
    input  logic [G_WIDTH-1:0] gpio_in_i,
    output logic [G_WIDTH-1:0] gpio_oen_o,
    output logic [G_WIDTH-1:0] gpio_out_o,
    output logic               irq_o,
    input  logic [ADR_W-1:0]   wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic               wb_we_i,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o
);

    logic [G_WIDTH-1:0] oen_q, out_q, rise_en_q, fall_en_q, status_q;
    logic [G_WIDTH-1:0] in_sync, in_rise, in_fall;
    logic [G_WIDTH-1:0] wdat, st_set, st_clr;
    logic [31:0]        rdata, dat_q;
    logic               ack_q, irq_q;
    logic               wb_req, wb_wr, wb_rd;
    logic               unused_dat;

    gpio_sync_edge #(
        .G_WIDTH       (G_WIDTH),
        .G_SYNC_STAGES (G_SYNC_STAGES)
    ) u_sync_edge (
        .clk_sys_i (clk_sys_i),
        .rst_n_i   (rst_n_i),
        .gpio_in_i (gpio_in_i),
        .sync      (in_sync),
        .rise      (in_rise),
        .fall      (in_fall)
    );

    assign wb_req     = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wb_wr      = wb_req & wb_we_i;
    assign wb_rd      = wb_req & ~wb_we_i;
    assign wdat       = wb_dat_i[G_WIDTH-1:0];
    assign unused_dat = ^wb_dat_i;

    // Set has priority over a same-cycle write-one-to-clear.
    assign st_set = (in_rise & rise_en_q) | (in_fall & fall_en_q);
    assign st_clr = (wb_wr && (wb_adr_i == ADDR_STATUS)) ? wdat : '0;

    always_comb begin
        rdata = '0;
        case (wb_adr_i)
            ADDR_OEN:                     rdata[G_WIDTH-1:0] = oen_q;
            ADDR_SET, ADDR_CLR, ADDR_OUT: rdata[G_WIDTH-1:0] = out_q;
            ADDR_IN:                      rdata[G_WIDTH-1:0] = in_sync;
            ADDR_RISE_EN:                 rdata[G_WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN:                 rdata[G_WIDTH-1:0] = fall_en_q;
            ADDR_STATUS:                  rdata[G_WIDTH-1:0] = status_q;
            default:                      rdata = '0;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            oen_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            if (wb_wr) begin
                case (wb_adr_i)
                    ADDR_OEN:     oen_q     <= wdat;
                    ADDR_SET:     out_q     <= out_q | wdat;
                    ADDR_CLR:     out_q     <= out_q & ~wdat;
                    ADDR_OUT:     out_q     <= wdat;
                    ADDR_RISE_EN: rise_en_q <= wdat;
                    ADDR_FALL_EN: fall_en_q <= wdat;
                    default:      ;
                endcase
            end
            status_q <= (status_q & ~st_clr) | st_set;
            irq_q    <= |status_q;
            ack_q    <= wb_req;
            if (wb_rd) begin
                dat_q <= rdata;
            end
        end
    end

    assign gpio_oen_o = oen_q;
    assign gpio_out_o = out_q;
    assign irq_o      = irq_q;
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Randomised and directed bench for wb_gpio_irq against a cycle-level behavioural model.
// A second 4-bit instance shares the bus to check width masking.
module tb_wb_gpio_irq;

    localparam int          W = 8;
    localparam int          S = 2;
    localparam logic [31:0] M = 32'h0000_00FF;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_oen, gpio_out;
    logic        irq;
    logic [4:0]  wb_adr   = '0;
    logic [31:0] wb_dat_w = '0;
    logic [31:0] wb_dat_r;
    logic        wb_we = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
    logic        wb_ack;

    logic [3:0]  g4_oen, g4_out;
    logic        g4_irq, g4_ack;
    logic [31:0] g4_dat_r;

    always #5 clk_sys = ~clk_sys;

    wb_gpio_irq #(.G_WIDTH(W), .G_SYNC_STAGES(S)) u_dut (
        .clk_sys_i (clk_sys),  .rst_n_i   (rst_n),
        .gpio_in_i (gpio_in),  .gpio_oen_o(gpio_oen),
        .gpio_out_o(gpio_out), .irq_o     (irq),
        .wb_adr_i  (wb_adr),   .wb_dat_i  (wb_dat_w),
        .wb_dat_o  (wb_dat_r), .wb_we_i   (wb_we),
        .wb_stb_i  (wb_stb),   .wb_cyc_i  (wb_cyc),
        .wb_ack_o  (wb_ack)
    );

    wb_gpio_irq #(.G_WIDTH(4), .G_SYNC_STAGES(S)) u_dut4 (
        .clk_sys_i (clk_sys),      .rst_n_i   (rst_n),
        .gpio_in_i (gpio_in[3:0]), .gpio_oen_o(g4_oen),
        .gpio_out_o(g4_out),       .irq_o     (g4_irq),
        .wb_adr_i  (wb_adr),       .wb_dat_i  (wb_dat_w),
        .wb_dat_o  (g4_dat_r),     .wb_we_i   (wb_we),
        .wb_stb_i  (wb_stb),       .wb_cyc_i  (wb_cyc),
        .wb_ack_o  (g4_ack)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: register contents plus the history of pad samples, one per clock edge.
    logic [31:0] m_oen, m_out, m_ren, m_fen, m_st, m_dat;
    logic        m_irq, m_ack;
    logic [31:0] hist[$];

    task automatic model_reset();
        m_oen = '0; m_out = '0; m_ren = '0; m_fen = '0; m_st = '0; m_dat = '0;
        m_irq = 1'b0; m_ack = 1'b0;
        hist.delete();
    endtask

    // Called just before a clock edge with the inputs that edge will sample.
    task automatic model_edge();
        logic [31:0] newv, oldv, set, clr, wd;
        int k;
        bit acc;
        hist.push_back({24'h0, gpio_in} & M);
        k    = hist.size() - 1;
        newv = (k >= S)     ? hist[k-S]   : 32'h0;
        oldv = (k >= S + 1) ? hist[k-S-1] : 32'h0;
        set  = ((newv & ~oldv & m_ren) | (~newv & oldv & m_fen)) & M;
        acc  = wb_cyc && wb_stb && !m_ack;
        wd   = wb_dat_w & M;
        clr  = '0;
        if (acc && !wb_we) begin
            case (wb_adr)
                5'h00:               m_dat = m_oen;
                5'h04, 5'h08, 5'h0C: m_dat = m_out;
                5'h10:               m_dat = newv;
                5'h14:               m_dat = m_ren;
                5'h18:               m_dat = m_fen;
                5'h1C:               m_dat = m_st;
                default:             m_dat = '0;
            endcase
        end
        m_irq = (m_st != 0);
        if (acc && wb_we) begin
            case (wb_adr)
                5'h00:   m_oen = wd;
                5'h04:   m_out = m_out | wd;
                5'h08:   m_out = m_out & ~wd;
                5'h0C:   m_out = wd;
                5'h14:   m_ren = wd;
                5'h18:   m_fen = wd;
                5'h1C:   clr   = wd;
                default: ;
            endcase
        end
        m_st  = (m_st & ~clr) | set;
        m_ack = acc;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_sys);
        #1;
        chk("ack",  {31'h0, wb_ack}, {31'h0, m_ack});
        chk("dat",  wb_dat_r, m_dat);
        chk("out",  {24'h0, gpio_out}, m_out);
        chk("oen",  {24'h0, gpio_oen}, m_oen);
        chk("irq",  {31'h0, irq}, {31'h0, m_irq});
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_adr = a; wb_dat_w = d; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        step();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        step();
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] d, output logic [31:0] d4);
        wb_adr = a; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        step();
        d  = wb_dat_r;
        d4 = g4_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] d, d4;
        logic [4:0]  a;
        int acks;
        int r;

        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_oen", {24'h0, gpio_oen}, 32'h0);
        chk("rst_out", {24'h0, gpio_out}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ack", {31'h0, wb_ack}, 32'h0);
        chk("rst_dat", wb_dat_r, 32'h0);
        @(negedge clk_sys);
        rst_n = 1'b1;

        // set then clear bits of OUT
        wb_write(5'h04, 32'h0000_00A5);
        wb_write(5'h08, 32'h0000_000F);
        chk("out_setclr", {24'h0, gpio_out}, 32'h0000_00A0);
        wb_read(5'h0C, d, d4);
        chk("rd_out", d, 32'h0000_00A0);

        // rising edge on line 0 -> status, irq, then clear
        wb_write(5'h14, 32'h0000_0001);
        gpio_in[0] = 1'b1;
        repeat (3) step();
        chk("irq_not_yet", {31'h0, irq}, 32'h0);
        step();
        chk("irq_lat", {31'h0, irq}, 32'h1);
        wb_read(5'h1C, d, d4);
        chk("st_rise", d, 32'h0000_0001);
        wb_write(5'h1C, 32'h0000_0001);
        chk("irq_clr", {31'h0, irq}, 32'h0);

        // falling edge on line 3 landing in the same cycle as its w1c
        wb_write(5'h18, 32'h0000_0008);
        gpio_in[3] = 1'b1; repeat (4) step();
        gpio_in[3] = 1'b0; repeat (4) step();
        gpio_in[3] = 1'b1; repeat (4) step();
        gpio_in[3] = 1'b0; step(); step();
        wb_write(5'h1C, 32'h0000_0008);
        wb_read(5'h1C, d, d4);
        chk("st_set_wins", d & 32'h8, 32'h0000_0008);

        // width masking and undecoded address
        wb_write(5'h00, 32'hFFFF_FFFF);
        chk("oen_w8", {24'h0, gpio_oen}, 32'h0000_00FF);
        chk("oen_w4", {28'h0, g4_oen}, 32'h0000_000F);
        wb_read(5'h00, d, d4);
        chk("rd_oen_w8", d, 32'h0000_00FF);
        chk("rd_oen_w4", d4, 32'h0000_000F);
        wb_write(5'h02, 32'hFFFF_FFFF);
        wb_read(5'h02, d, d4);
        chk("rd_unmapped", d, 32'h0);

        // held strobe: ack every second cycle
        wb_adr = 5'h10; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        acks = 0;
        repeat (6) begin
            step();
            if (wb_ack) acks++;
        end
        chk("ack_count", acks, 3);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        step();

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 8) a = 5'($urandom_range(0, 7) * 4);
            else                          a = 5'($urandom);
            if (r < 4) begin
                gpio_in = W'($urandom);
                step();
            end else if (r < 7) begin
                wb_write(a, $urandom);
            end else begin
                wb_read(a, d, d4);
            end
        end

        // ensure irq pending, then reset in the middle of a write
        wb_write(5'h14, 32'h0000_00FF);
        gpio_in = '0; repeat (4) step();
        gpio_in = 8'hFF; repeat (4) step();
        chk("irq_pre_rst", {31'h0, irq}, 32'h1);
        wb_adr = 5'h0C; wb_dat_w = 32'h55; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_irq", {31'h0, irq}, 32'h0);
        chk("rst_mid_out", {24'h0, gpio_out}, 32'h0);
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_mid_ack", {31'h0, wb_ack}, 32'h0);
        chk("rst_mid_oen", {24'h0, gpio_oen}, 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        gpio_in = '0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            wb_read(5'(j * 4), d, d4);
            chk("rd_after_rst", d, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_gpio_irq.md
WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

Interface
REQ-001 SHALL have parameter G_WIDTH, default 8, number of GPIO lines (legal 1..32).
REQ-002 SHALL have parameter G_SYNC_STAGES, default 2, input synchroniser depth (legal 2..4).
REQ-003 SHALL have port clk_sys_i  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gpio_in_i  in  G_WIDTH  asynchronous pad inputs.
REQ-006 SHALL have port gpio_oen_o  out  G_WIDTH  output enable per line, 1 = driving.
REQ-007 SHALL have port gpio_out_o  out  G_WIDTH  output data per line.
REQ-008 SHALL have port irq_o  out  1  level interrupt, OR of enabled pending bits.
REQ-009 SHALL have ports wb_adr_i in 5 (byte address), wb_dat_i in 32, wb_dat_o out 32, wb_we_i in 1, wb_stb_i in 1, wb_cyc_i in 1, wb_ack_o out 1 (Wishbone classic slave).

Function
REQ-010 SHALL decode the register map: 0x00 OEN rw; 0x04 SET w1s on OUT, reads OUT; 0x08 CLR w1c on OUT, reads OUT; 0x0C OUT rw; 0x10 IN ro (synchronised inputs); 0x14 RISE_EN rw; 0x18 FALL_EN rw; 0x1C STATUS rw1c.
REQ-011 SHALL treat a transaction as wb_cyc_i & wb_stb_i & !wb_ack_o; ack SHALL assert exactly one cycle after the transaction is accepted and last exactly one cycle.
REQ-012 SHALL not insert back-to-back acks: with stb held high, acks SHALL occur every second cycle.
REQ-013 SHALL register wb_dat_o on the accepted read cycle, valid with wb_ack_o; wb_dat_o SHALL hold its value otherwise.
REQ-014 SHALL take write effect on the accepted cycle; new register values are visible on outputs in the cycle ack is high.
REQ-015 SHALL read bits [31:G_WIDTH] as 0 and ignore writes to them; unmapped addresses SHALL read 0, ignore writes, and still ack.
REQ-016 SHALL pass gpio_in_i through G_SYNC_STAGES flip-flops; IN reads the last stage.
REQ-017 SHALL detect edges by comparing last sync stage with one further delayed copy: rising = 0->1, falling = 1->0.
REQ-018 SHALL set STATUS[i] on a detected edge whose enable bit (RISE_EN[i] or FALL_EN[i]) is 1; disabled edges SHALL not set STATUS.
REQ-019 SHALL clear STATUS[i] when 1 is written to bit i at 0x1C; if an edge sets bit i in the same cycle, set SHALL win.
REQ-020 SHALL drive irq_o registered = |STATUS; clearing all bits lowers irq_o next cycle.
REQ-021 SHALL not retroactively flag edges when an enable bit is written to 1; only edges detected after the write count.
REQ-022 SHALL keep input-to-STATUS latency G_SYNC_STAGES+1 cycles from pad change sampled to STATUS bit set.

Reset
REQ-023 SHALL on rst_n_i low asynchronously clear OEN, OUT, RISE_EN, FALL_EN, STATUS, synchroniser and delay flops, wb_dat_o, wb_ack_o, irq_o to 0.
REQ-024 SHALL abort any transaction in flight at reset with no ack; first edge-detect after release SHALL not fire on a 0->0 history (delay flop reset to 0, a high input after reset SHALL produce one rising event if enabled).

Structure
REQ-025 SHALL place register address constants (ADDR_OEN .. ADDR_STATUS) in shared package wb_gpio_pkg.
REQ-026 SHALL implement synchroniser plus edge detector as sub-module gpio_sync_edge (parametrised G_WIDTH, G_SYNC_STAGES), outputs sync, rise, fall.

Verification
REQ-027 SHALL check: write 0xA5 to 0x04 then 0x0F to 0x08 -> gpio_out_o = 0xA0, read 0x0C returns 0x000000A0.
REQ-028 SHALL check: RISE_EN=0x01, drive gpio_in_i[0] 0->1 -> STATUS=0x01 after 3 cycles (default stages), irq_o high next cycle; write 0x01 to 0x1C -> irq_o low.
REQ-029 SHALL check: edge on bit 3 with FALL_EN=0x08 in same cycle as w1c of bit 3 -> STATUS[3] remains 1.
REQ-030 SHALL check: G_WIDTH=4, write 0xFFFFFFFF to 0x00 -> read returns 0x0000000F; read 0x1E-style unmapped 0x18+4 aliases excluded, read undecoded 0x02 returns 0 with ack.
REQ-031 SHALL check: stb/cyc held high 6 cycles -> exactly 3 single-cycle acks.
REQ-032 SHALL check: assert rst_n_i mid-write -> no ack, all registers 0, irq_o 0.
